mul_div_unit: RTL
=================

Name: mul_div_unit

Overview:
- Parametrised, multi-cycle integer multiply/divide unit with architectural HI/LO registers.
- Sits beside the combinational ALU in the EX stage of the dual-issue pipeline.
- Executes MULT/MULTU/DIV/DIVU iteratively, one bit per cycle, and writes MTHI/MTLO in a single cycle.
- Uses a start/busy/done handshake so the hazard unit stalls dependent MFHI/MFLO reads while busy is high.

Parameters:
- WIDTH, 32, operand width and width of each of HI and LO (≥4).
- CNT_W, $clog2(WIDTH), width of the iteration counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others no-op.
- op1  in  WIDTH  multiplicand/dividend, or MTHI/MTLO source.
- op2  in  WIDTH  multiplier/divisor.
- flush  in  1  abort the in-flight operation (branch mispredict/exception).
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse when HI/LO are updated by a mult/div.
- div_by_zero  out  1  valid with done; divisor was zero.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; busy=0, done=0, div_by_zero=0, hi=0, lo=0, counter=0.
- States: IDLE, RUN, FIX.
- IDLE:
  - start & op∈{MULT,MULTU,DIV,DIVU} at edge N → RUN. At that edge: latch |op1| and |op2| (absolute values for signed ops, raw values for unsigned ops), result sign, dividend sign; counter=0; busy=1.
  - start & MTHI/MTLO at edge N → hi or lo = op1 at that edge; stay IDLE; no busy, no done.
  - Undefined op, or start=0 → no change.
- RUN: one iteration per edge.
  - Multiply: shift-add radix-2 into a 2·WIDTH accumulator.
  - Divide: restoring, one quotient bit per cycle.
  - Edges N+1..N+WIDTH. At the edge where counter==WIDTH-1 → FIX.
- FIX (edge N+WIDTH+1):
  - Apply sign correction, then write hi/lo.
  - done=1 and busy=0 for the following cycle; return to IDLE.
- Latency: done is high in the cycle after edge N+WIDTH+1. busy is high in cycles N+1..N+WIDTH+1.
- Sign rules:
  - Product is negated if the operand signs differ; hi=upper WIDTH bits, lo=lower WIDTH bits.
  - Quotient (→lo) is negated if the operand signs differ. Remainder (→hi) takes the dividend's sign.
- Overflow case, DIV of most-negative by -1: lo=most-negative (two's-complement wrap), hi=0, div_by_zero=0.
- Divide by zero: at edge N go straight to FIX, skipping RUN. Result hi=op1 (raw), lo=all ones, div_by_zero=1 with done; busy is high for one cycle only.
- start while busy: ignored; the request is not queued (the pipeline guarantees a stall).
- flush: at the next edge go to IDLE, busy=0, no done; hi/lo keep their pre-operation values.
- flush and start in the same IDLE cycle: flush wins and nothing is launched. flush in FIX: the write is suppressed.
- hi/lo change only on FIX or MTHI/MTLO.
- MFHI/MFLO read hi/lo combinationally. Values are architecturally valid only when busy=0.
- Async reset mid-operation: immediate return to reset values.

Decomposition:
- Shared package mdu_pkg:
  - op encodings MDU_MULT..MDU_MTLO;
  - state enum {IDLE, RUN, FIX};
  - localparam of the all-ones quotient pattern for divide by zero.
- One natural sub-module: mdu_iter_step. It is the combinational single-iteration datapath: shift-add for multiply, trial subtract for divide, selected by a mode bit. The top holds the FSM, counter, sign latches and HI/LO.

Test Plan (WIDTH=32, start at edge N):
- MULT op1=-3, op2=5 → done in cycle N+34; hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy high for exactly 33 cycles.
- MULTU op1=op2=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; a second start pulsed mid-run is ignored, with a single done.
- DIV op1=-7, op2=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0, div_by_zero=0.
- DIVU op1=100, op2=0 → done in cycle N+2, div_by_zero=1, hi=100, lo=0xFFFFFFFF.
- MTHI 0x12345678, then MTLO 0x9 → hi/lo update at the next edge, busy and done stay 0. Then start MULT and flush at N+10 → busy=0 at N+11, no done, hi=0x12345678 and lo=0x9 retained.
- rst asserted asynchronously mid-RUN (cycle N+15) → busy, hi and lo go to 0 immediately. After release, a new MULTU 7×6 gives lo=42, hi=0.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared encodings and constants for the multiply/divide unit.
package mdu_pkg;

  // Operation encodings on the op port
  localparam logic [2:0] MDU_MULT  = 3'b000;
  localparam logic [2:0] MDU_MULTU = 3'b001;
  localparam logic [2:0] MDU_DIV   = 3'b010;
  localparam logic [2:0] MDU_DIVU  = 3'b011;
  localparam logic [2:0] MDU_MTHI  = 3'b100;
  localparam logic [2:0] MDU_MTLO  = 3'b101;

  // Control FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } mdu_state_e;

  // Quotient reported on divide by zero: every bit set, replicated to WIDTH
  localparam logic MDU_DIV0_QUOT_FILL = 1'b1;

endpackage

// File: rtl/mdu_iter_step.sv
// Single iteration of the iterative datapath: radix-2 shift-add multiply
// or one restoring-division step, selected by div_mode_i.
module mdu_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic                 div_mode_i,
  input  logic [2*WIDTH-1:0]   acc_i,
  input  logic [WIDTH-1:0]     opnd_i,
  output logic [2*WIDTH-1:0]   acc_o
);

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;
  logic             fits;

  // Multiply: acc = {partial, multiplier}; add multiplicand on lsb, shift right.
  // Divide: acc = {remainder, dividend/quotient}; shift left, trial subtract.
  always_comb begin
    mul_sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
    rem_sh  = acc_i[2*WIDTH-1:WIDTH-1];
    fits    = (rem_sh >= {1'b0, opnd_i});
    // Remainder stays below the divisor, so the low WIDTH bits hold the difference
    diff    = rem_sh[WIDTH-1:0] - opnd_i;
    if (div_mode_i) begin
      acc_o = {(fits ? diff : rem_sh[WIDTH-1:0]), acc_i[WIDTH-2:0], fits};
    end else begin
      acc_o = {mul_sum, acc_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One result bit per cycle; start/busy/done handshake toward the hazard unit.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int W2 = 2 * WIDTH;

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  // Per-operation working state, always loaded at launch before use
  logic [W2-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             is_div_q, is_div_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             div0_q, div0_d;

  logic [W2-1:0]    acc_step;
  logic             is_mul_op, is_div_op, is_signed_op, op2_zero;
  logic [WIDTH-1:0] mag1, mag2;
  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                 input logic sgn);
    // Most-negative maps onto itself, which is its correct unsigned magnitude
    return (sgn && (v < 0)) ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic n);
    return n ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [W2-1:0] cond_neg2(input logic [W2-1:0] v, input logic n);
    return n ? (~v + W2'(1)) : v;
  endfunction

  mdu_iter_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .div_mode_i(is_div_q),
    .acc_i     (acc_q),
    .opnd_i    (opnd_q),
    .acc_o     (acc_step)
  );

  // Operand decode and sign-corrected results for the FIX write
  always_comb begin
    is_mul_op    = (op == MDU_MULT) || (op == MDU_MULTU);
    is_div_op    = (op == MDU_DIV)  || (op == MDU_DIVU);
    is_signed_op = (op == MDU_MULT) || (op == MDU_DIV);
    op2_zero     = (op2 == '0);
    mag1         = magnitude(op1, is_signed_op);
    mag2         = magnitude(op2, is_signed_op);
    prod_fix     = cond_neg2(acc_q, neg_res_q);
    quo_fix      = cond_neg(acc_q[WIDTH-1:0], neg_res_q);
    rem_fix      = cond_neg(acc_q[W2-1:WIDTH], neg_rem_q);
  end

  // Next-state: FSM, counter, HI/LO and launch-time operand capture
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    dbz_d     = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !flush) begin
          if (is_mul_op || is_div_op) begin
            cnt_d     = '0;
            is_div_d  = is_div_op;
            neg_res_d = is_signed_op && (op1[WIDTH-1] ^ op2[WIDTH-1]);
            neg_rem_d = is_signed_op && op1[WIDTH-1];
            div0_d    = is_div_op && op2_zero;
            if (is_div_op && op2_zero) begin
              // Raw dividend to HI, all-ones quotient to LO, no sign fixup
              acc_d     = {op1, {WIDTH{MDU_DIV0_QUOT_FILL}}};
              opnd_d    = op2;
              neg_res_d = 1'b0;
              neg_rem_d = 1'b0;
              state_d   = ST_FIX;
            end else if (is_div_op) begin
              acc_d   = {{WIDTH{1'b0}}, mag1};
              opnd_d  = mag2;
              state_d = ST_RUN;
            end else begin
              acc_d   = {{WIDTH{1'b0}}, mag2};
              opnd_d  = mag1;
              state_d = ST_RUN;
            end
          end else if (op == MDU_MTHI) begin
            hi_d = op1;
          end else if (op == MDU_MTLO) begin
            lo_d = op1;
          end
        end
      end
      ST_RUN: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          acc_d = acc_step;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = ST_FIX;
          end
        end
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        if (!flush) begin
          done_d = 1'b1;
          dbz_d  = div0_q;
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and architectural registers, asynchronously cleared
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Working datapath registers, no reset needed
  always_ff @(posedge clk) begin
    acc_q     <= acc_d;
    opnd_q    <= opnd_d;
    is_div_q  <= is_div_d;
    neg_res_q <= neg_res_d;
    neg_rem_q <= neg_rem_d;
    div0_q    <= div0_d;
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule
